axis_fanout_buf: RTL and testbench

// Parametrised AXI-Stream broadcast stage: each of N_IN input streams is copied to FANOUT

---
 rtl/axis_fanout_buf.sv | 53 +++++
 tb/tb_axis_fanout_buf.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fanout_buf.sv
// AXI-Stream broadcast stage: each input word is buffered once and copied to FANOUT outputs.
// Copies retire independently (eager fork); the buffer refills as soon as every pending copy drains.
module axis_fanout_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_IN   = 2,
    parameter int unsigned FANOUT = 2
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst,
    input  logic [N_IN*FANOUT-1:0]          out_en,
    input  logic [N_IN*DATA_W-1:0]          Input_V_TDATA,
    input  logic [N_IN-1:0]                 Input_V_TVALID,
    output logic [N_IN-1:0]                 Input_V_TREADY,
    output logic [N_IN*FANOUT*DATA_W-1:0]   Output_V_TDATA,
    output logic [N_IN*FANOUT-1:0]          Output_V_TVALID,
    input  logic [N_IN*FANOUT-1:0]          Output_V_TREADY,
    output logic                            ap_idle
);

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        logic [DATA_W-1:0] r_data;
        logic [FANOUT-1:0] r_pend;
        logic [FANOUT-1:0] w_done;
        logic              w_drain;
        logic              w_accept;

        assign w_done   = r_pend & Output_V_TREADY[i*FANOUT +: FANOUT];
        // Ready as soon as the last outstanding copy retires this cycle, for full throughput.
        assign w_drain  = ((r_pend & ~w_done) == '0);
        assign Input_V_TREADY[i] = ~ap_rst & w_drain;
        assign w_accept = Input_V_TVALID[i] & Input_V_TREADY[i];

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                r_data <= '0;
                r_pend <= '0;
            end else if (w_accept) begin
                r_data <= Input_V_TDATA[i*DATA_W +: DATA_W];
                r_pend <= out_en[i*FANOUT +: FANOUT];
            end else begin
                r_pend <= r_pend & ~w_done;
            end
        end

        assign Output_V_TVALID[i*FANOUT +: FANOUT] = r_pend;
        for (genvar k = 0; k < FANOUT; k++) begin : g_copy
            assign Output_V_TDATA[(i*FANOUT+k)*DATA_W +: DATA_W] = r_data;
        end
    end

    assign ap_idle = ~|Output_V_TVALID;

endmodule

// File: tb/tb_axis_fanout_buf.sv
// Directed and random checks of axis_fanout_buf using per-output expected-word queues.
module tb_axis_fanout_buf;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters (DATA_W=32, N_IN=2, FANOUT=2)
    logic         a_rst;
    logic [3:0]   a_en;
    logic [63:0]  a_idata;
    logic [1:0]   a_ivalid;
    logic [1:0]   a_iready;
    logic [127:0] a_odata;
    logic [3:0]   a_ovalid;
    logic [3:0]   a_oready;
    logic         a_idle;

    axis_fanout_buf dut_a (
        .ap_clk          (clk),
        .ap_rst          (a_rst),
        .out_en          (a_en),
        .Input_V_TDATA   (a_idata),
        .Input_V_TVALID  (a_ivalid),
        .Input_V_TREADY  (a_iready),
        .Output_V_TDATA  (a_odata),
        .Output_V_TVALID (a_ovalid),
        .Output_V_TREADY (a_oready),
        .ap_idle         (a_idle)
    );

    // DUT B: DATA_W=16, N_IN=3, FANOUT=4
    logic         b_rst;
    logic [11:0]  b_en;
    logic [47:0]  b_idata;
    logic [2:0]   b_ivalid;
    logic [2:0]   b_iready;
    logic [191:0] b_odata;
    logic [11:0]  b_ovalid;
    logic [11:0]  b_oready;
    logic         b_idle;

    axis_fanout_buf #(
        .DATA_W (16),
        .N_IN   (3),
        .FANOUT (4)
    ) dut_b (
        .ap_clk          (clk),
        .ap_rst          (b_rst),
        .out_en          (b_en),
        .Input_V_TDATA   (b_idata),
        .Input_V_TVALID  (b_ivalid),
        .Input_V_TREADY  (b_iready),
        .Output_V_TDATA  (b_odata),
        .Output_V_TVALID (b_ovalid),
        .Output_V_TREADY (b_oready),
        .ap_idle         (b_idle)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] qa [4][$];
    logic [15:0] qb [12][$];
    logic [2:0]  b_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Retire output handshakes against the queues, then record accepted inputs.
    task automatic a_sample();
        logic [31:0] exp;
        for (int o = 0; o < 4; o++) begin
            if (a_ovalid[o] && a_oready[o]) begin
                check($sformatf("a_out%0d_expected_word", o), 64'(qa[o].size() != 0), 64'(1));
                if (qa[o].size() != 0) begin
                    exp = qa[o].pop_front();
                    check($sformatf("a_out%0d_data", o), 64'(a_odata[o*32 +: 32]), 64'(exp));
                end
            end
        end
        for (int i = 0; i < 2; i++)
            if (a_ivalid[i] && a_iready[i])
                for (int k = 0; k < 2; k++)
                    if (a_en[i*2+k]) qa[i*2+k].push_back(a_idata[i*32 +: 32]);
    endtask

    task automatic a_cycle();
        #1;
        a_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic b_sample();
        logic [15:0] exp;
        for (int o = 0; o < 12; o++) begin
            if (b_ovalid[o] && b_oready[o]) begin
                check($sformatf("b_out%0d_expected_word", o), 64'(qb[o].size() != 0), 64'(1));
                if (qb[o].size() != 0) begin
                    exp = qb[o].pop_front();
                    check($sformatf("b_out%0d_data", o), 64'(b_odata[o*16 +: 16]), 64'(exp));
                end
            end
        end
        for (int i = 0; i < 3; i++)
            if (b_ivalid[i] && b_iready[i])
                for (int k = 0; k < 4; k++)
                    if (b_en[i*4+k]) qb[i*4+k].push_back(b_idata[i*16 +: 16]);
        b_acc = b_ivalid & b_iready;
    endtask

    initial begin
        a_rst = 1'b1; a_en = 4'hF; a_idata = {32'hDEAD0001, 32'hDEAD0000};
        a_ivalid = 2'b11; a_oready = 4'hF;
        b_rst = 1'b1; b_en = '0; b_idata = '0; b_ivalid = '0; b_oready = '0; b_acc = '0;

        // 1: reset with inputs valid
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst_iready", 64'(a_iready), 64'(0));
            check("rst_ovalid", 64'(a_ovalid), 64'(0));
            check("rst_odata", 64'(a_odata), 64'(0));
            check("rst_idle", 64'(a_idle), 64'(1));
        end
        a_rst = 1'b0; a_ivalid = 2'b00;
        a_cycle();

        // 2: back-to-back streaming on input 0
        for (int w = 1; w <= 16; w++) begin
            a_ivalid = 2'b01; a_idata[31:0] = 32'(w);
            #1;
            check("stream_iready", 64'(a_iready[0]), 64'(1));
            a_cycle();
            if (w == 1) check("stream_first_valid", 64'(a_ovalid), 64'(4'b0011));
        end
        a_ivalid = 2'b00;
        a_cycle();
        check("stream_drained_idle", 64'(a_idle), 64'(1));
        check("stream_q0_empty", 64'(qa[0].size()), 64'(0));
        check("stream_q1_empty", 64'(qa[1].size()), 64'(0));

        // 3: skewed stall on output 1
        a_ivalid = 2'b01; a_idata[31:0] = 32'hA;
        a_cycle();
        a_idata[31:0] = 32'hB; a_oready = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("skew_iready_low", 64'(a_iready[0]), 64'(0));
            a_cycle();
            check("skew_out0_once", 64'(a_ovalid[1:0]), 64'(2'b10));
        end
        a_oready = 4'hF;
        #1;
        check("skew_iready_release", 64'(a_iready[0]), 64'(1));
        a_cycle();
        a_ivalid = 2'b00;
        check("skew_b_valid", 64'(a_ovalid[1:0]), 64'(2'b11));
        a_cycle();
        check("skew_q_empty", 64'(qa[0].size() + qa[1].size()), 64'(0));

        // 4: output enable mask
        a_en = 4'b0101; a_oready = 4'b0000;
        a_ivalid = 2'b11; a_idata = {32'hBB, 32'hAA};
        a_cycle();
        a_ivalid = 2'b00;
        check("mask_valid", 64'(a_ovalid), 64'(4'b0101));
        check("mask_out0", 64'(a_odata[31:0]), 64'(32'hAA));
        check("mask_out2", 64'(a_odata[95:64]), 64'(32'hBB));
        a_oready = 4'hF;
        a_cycle();
        a_en = 4'b0100; a_ivalid = 2'b01; a_idata[31:0] = 32'hCC;
        a_cycle();
        a_ivalid = 2'b00;
        check("mask_zero_valid", 64'(a_ovalid), 64'(0));
        check("mask_zero_idle", 64'(a_idle), 64'(1));
        check("mask_zero_iready", 64'(a_iready[0]), 64'(1));

        // 5: reset while out3 holds 0x55
        a_en = 4'hF; a_oready = 4'b0111;
        a_ivalid = 2'b10; a_idata[63:32] = 32'h55;
        a_cycle();
        a_ivalid = 2'b00;
        a_cycle();
        check("midrst_out3_held", 64'(a_ovalid), 64'(4'b1000));
        check("midrst_out3_data", 64'(a_odata[127:96]), 64'(32'h55));
        a_rst = 1'b1;
        a_cycle();
        for (int o = 0; o < 4; o++) qa[o].delete();
        a_rst = 1'b0;
        check("midrst_out3_dropped", 64'(a_ovalid[3]), 64'(0));
        a_oready = 4'hF;
        #1;
        check("midrst_iready1", 64'(a_iready[1]), 64'(1));
        for (int c = 0; c < 3; c++) begin
            a_cycle();
            check("midrst_no_valid", 64'(a_ovalid), 64'(0));
        end

        // 6: random traffic on the 3x4 instance
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            b_oready = 12'($urandom);
            b_en     = 12'($urandom);
            for (int i = 0; i < 3; i++) begin
                if (!(b_ivalid[i] && !b_acc[i])) begin
                    b_ivalid[i] = ($urandom_range(0, 3) != 0);
                    b_idata[i*16 +: 16] = 16'($urandom);
                end
            end
            #1;
            b_sample();
        end
        @(posedge clk);
        #1;
        b_ivalid = '0; b_oready = '1;
        for (int c = 0; c < 4; c++) begin
            #1;
            b_sample();
            @(posedge clk);
            #1;
        end
        for (int o = 0; o < 12; o++)
            check($sformatf("rand_q%0d_empty", o), 64'(qb[o].size()), 64'(0));
        check("rand_idle", 64'(b_idle), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
